// File: rtl/data_cache_responder.sv
// Direct-mapped, write-back, write-allocate data cache that answers the CPU READ/WRITE/BUSYWAIT
// handshake and moves whole blocks to and from a main memory using the same handshake.
module data_cache_responder #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int IW     = $clog2(NUM_BLOCKS);
    localparam int TW     = 6 - IW;
    localparam int LINE_W = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                  state;
    logic                    done;
    logic [LINE_W-1:0]       data_q [NUM_BLOCKS];
    logic [TW-1:0]           tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]   valid_q;
    logic [NUM_BLOCKS-1:0]   dirty_q;
    logic [LINE_W-1:0]       fill_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] atag;
    logic [1:0]    off;
    logic          req;
    logic          hit;
    logic          service;

    assign idx     = ADDRESS[IW+1:2];
    assign atag    = ADDRESS[7:IW+2];
    assign off     = ADDRESS[1:0];
    assign req     = READ | WRITE;
    assign hit     = valid_q[idx] && (tag_q[idx] == atag);
    assign service = (state == IDLE) && req && !done && hit;

    always_comb begin
        BUSYWAIT = 1'b1;
        if (state == IDLE)
            BUSYWAIT = req & ~done;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            done          <= 1'b0;
            READDATA      <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            valid_q       <= '0;
            dirty_q       <= '0;
            fill_q        <= '0;
        end else begin
            // done survives only while the CPU still holds the serviced request
            if (!req)
                done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !done) begin
                        if (hit) begin
                            if (WRITE)
                                dirty_q[idx] <= 1'b1;
                            else
                                READDATA <= data_q[idx][{off, 3'b000} +: 8];
                            done <= 1'b1;
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tag_q[idx], idx};
                            MEM_WRITEDATA <= data_q[idx];
                        end else begin
                            state       <= FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {atag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= FETCH;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= {atag, idx};
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                        fill_q   <= MEM_READDATA;
                    end
                end
                UPDATE: begin
                    state        <= IDLE;
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; reset forces IDLE so an abandoned fill never lands.
    always_ff @(posedge CLK) begin
        if (service && WRITE) begin
            data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end else if (state == UPDATE) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= atag;
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Directed bench for data_cache_responder with a small latency-modelled main memory.
module tb_data_cache_responder;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ, MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] mem [64];
    logic        mem_loaded = 1'b0;
    int          cnt = LAT;
    logic        overlap = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    logic        saw_rd, saw_wr;
    logic [5:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  exp_b [4];

    data_cache_responder dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for LAT cycles of a request, completes on the following edge.
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != 0);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]     <= 32'h44332211;
            mem[3]     <= 32'h1F2E3D4C;
            mem[9]     <= 32'h88776655;
            mem[6'h11] <= 32'hCCBBAA99;
            mem_loaded <= 1'b1;
        end else if (!(MEM_READ | MEM_WRITE)) begin
            cnt <= LAT;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end else begin
            if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            cnt <= LAT;
        end
    end

    always @(negedge CLK) if (MEM_READ && MEM_WRITE) overlap <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input bit hold);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        do begin
            @(posedge CLK); @(negedge CLK);
            cyc++;
            if (MEM_READ && !saw_rd) begin saw_rd = 1'b1; rd_addr = MEM_ADDRESS; end
            if (MEM_WRITE && !saw_wr) begin
                saw_wr = 1'b1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA;
            end
        end while (BUSYWAIT && cyc < 100);
        check("req_completes", BUSYWAIT, 1'b0);
        if (hold) begin
            @(posedge CLK); @(negedge CLK);
            check("hold_busy_low", BUSYWAIT, 1'b0);
            check("hold_no_mem", MEM_READ | MEM_WRITE, 1'b0);
        end
        READ = 1'b0; WRITE = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        check("rst_busy", BUSYWAIT, 0);
        check("rst_rdata", READDATA, 0);
        check("rst_mrd", MEM_READ, 0);
        check("rst_mwr", MEM_WRITE, 0);
        check("rst_maddr", MEM_ADDRESS, 0);
        check("rst_mwdata", MEM_WRITEDATA, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Clean miss: IDLE edge + 5 FETCH + UPDATE + service = 8 edges
        do_req(1, 0, 8'h05, 8'h00, 0);
        check("t1_rdata", READDATA, 8'h22);
        check("t1_fetch", saw_rd, 1);
        check("t1_faddr", rd_addr, 6'h01);
        check("t1_nowb", saw_wr, 0);
        check("t1_cycles", cyc, 8);

        do_req(0, 1, 8'h06, 8'hAB, 0);
        check("t2_wr_cycles", cyc, 1);
        check("t2_wr_nomem", saw_rd | saw_wr, 0);
        check("t2_rdata_kept", READDATA, 8'h22);
        do_req(1, 0, 8'h06, 8'h00, 0);
        check("t2_rd_cycles", cyc, 1);
        check("t2_rdata", READDATA, 8'hAB);

        // Dirty miss: IDLE + 5 WRITEBACK + 5 FETCH + UPDATE + service = 13 edges
        do_req(1, 0, 8'h26, 8'h00, 0);
        check("t3_wb", saw_wr, 1);
        check("t3_wbaddr", wr_addr, 6'h01);
        check("t3_wbdata", wr_data, 32'h44AB2211);
        check("t3_faddr", rd_addr, 6'h09);
        check("t3_rdata", READDATA, 8'h77);
        check("t3_cycles", cyc, 13);
        check("t3_mem1", mem[1], 32'h44AB2211);

        do_req(1, 0, 8'h0C, 8'h00, 0);
        check("t4_pre_rdata", READDATA, 8'h4C);
        check("t4_pre_cycles", cyc, 8);

        READ = 1'b1; ADDRESS = 8'h45;
        repeat (3) @(negedge CLK);
        check("t4_in_fetch", MEM_READ, 1);
        check("t4_fetch_addr", MEM_ADDRESS, 6'h11);
        #2 RESET = 1'b0;
        #1;
        check("t4_mrd_drop", MEM_READ, 0);
        check("t4_rdata_rst", READDATA, 0);
        @(negedge CLK);
        RESET = 1'b1;
        do_req(1, 0, 8'h45, 8'h00, 0);
        check("t4_refetch", saw_rd, 1);
        check("t4_refetch_addr", rd_addr, 6'h11);
        check("t4_rdata", READDATA, 8'hAA);
        check("t4_cycles", cyc, 8);
        do_req(1, 0, 8'h0C, 8'h00, 0);
        check("t4_line3_invalid", saw_rd, 1);
        check("t4_line3_rdata", READDATA, 8'h4C);

        do_req(1, 1, 8'h0D, 8'h5A, 0);
        check("t5_both_cycles", cyc, 1);
        check("t5_both_rdata", READDATA, 8'h4C);
        do_req(1, 0, 8'h0D, 8'h00, 1);
        check("t5_rdata", READDATA, 8'h5A);
        check("t5_cycles", cyc, 1);

        exp_b[0] = 8'h4C; exp_b[1] = 8'h5A; exp_b[2] = 8'h2E; exp_b[3] = 8'h1F;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 0, 8'(8'h0C + i), 8'h00, 0);
            check("t6_rdata", READDATA, exp_b[i]);
            check("t6_cycles", cyc, 1);
            check("t6_nomem", saw_rd | saw_wr, 0);
        end

        check("no_rd_wr_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
